// File: rtl/byteena_reg_bank_pkg.sv
// rtl/byteena_reg_bank_pkg.sv - shared types and helpers for the byte-enable register bank
package byteena_reg_bank_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  function automatic int num_bytes(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/byteena_merge.sv
// rtl/byteena_merge.sv - per-byte merge of a new word over an old word
module byteena_merge
  import byteena_reg_bank_pkg::*;
#(
  parameter  int DATA_W    = 16,
  localparam int NUM_BYTES = num_bytes(DATA_W)
) (
  input  logic [DATA_W-1:0]    old_word,
  input  logic [DATA_W-1:0]    new_word,
  input  logic [NUM_BYTES-1:0] byteena,
  output logic [DATA_W-1:0]    merged_word
);

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (byteena[i]) begin
        merged_word[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/byteena_reg_bank.sv
// rtl/byteena_reg_bank.sv - DEPTH x DATA_W register bank with byte enables,
// 1-cycle reads with write forwarding, and a sequential clear sweep
module byteena_reg_bank
  import byteena_reg_bank_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int DEPTH     = 8,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int NUM_BYTES = num_bytes(DATA_W)
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [NUM_BYTES-1:0] byteena,
  input  logic                 rd_req,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic                 rd_valid,
  output logic [DATA_W-1:0]    rd_data,
  input  logic                 clr,
  output logic                 busy,
  output logic [DEPTH-1:0]     word_vld
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DEPTH-1:0]    word_vld_q, word_vld_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                ready_en_q, ready_en_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  logic                wr_hit;
  logic [DATA_W-1:0]   wr_old;
  logic [DATA_W-1:0]   wr_merged;
  logic                wr_fire;
  logic                wr_commit;
  logic                fwd;
  logic [DATA_W-1:0]   rd_word;
  logic                rd_word_vld;

  // Address decode by comparison keeps out-of-range addresses from ever indexing storage.
  always_comb begin
    wr_hit      = 1'b0;
    wr_old      = '0;
    rd_word     = '0;
    rd_word_vld = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (wr_addr == ADDR_W'(k)) begin
        wr_hit = 1'b1;
        wr_old = mem_q[k];
      end
      if (rd_addr == ADDR_W'(k)) begin
        rd_word     = mem_q[k];
        rd_word_vld = word_vld_q[k];
      end
    end
  end

  byteena_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .old_word    (wr_old),
    .new_word    (wr_data),
    .byteena     (byteena),
    .merged_word (wr_merged)
  );

  assign wr_fire   = wr_valid && wr_ready;
  assign wr_commit = wr_fire && wr_hit && (|byteena);
  assign fwd       = wr_commit && (wr_addr == rd_addr);

  // FSM: next state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy     = (state_q == CLEAR);
    wr_ready = ready_en_q && (state_q == IDLE) && !clr;
  end

  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < DEPTH; k++) begin
      if ((state_q == CLEAR) && (ptr_q == ADDR_W'(k))) begin
        mem_d[k] = '0;
      end else if (wr_commit && (wr_addr == ADDR_W'(k))) begin
        mem_d[k] = wr_merged;
      end
    end
  end

  always_comb begin
    word_vld_d = word_vld_q;
    if ((state_q == IDLE) && clr) begin
      word_vld_d = '0;
    end else if (wr_commit) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (wr_addr == ADDR_W'(k)) begin
          word_vld_d[k] = 1'b1;
        end
      end
    end
  end

  // A same-edge write to the read address returns the merged word, not the stale one.
  always_comb begin
    rd_valid_d = rd_req;
    rd_data_d  = rd_data_q;
    if (rd_req) begin
      if (fwd) begin
        rd_data_d = wr_merged;
      end else if (rd_word_vld) begin
        rd_data_d = rd_word;
      end else begin
        rd_data_d = '0;
      end
    end
  end

  assign ready_en_d = 1'b1;

  // FSM: state register plus the remaining control/read flops
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      word_vld_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      word_vld_q <= word_vld_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      ready_en_q <= ready_en_d;
    end
  end

  // Storage is deliberately left out of reset; word_vld masks its contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign word_vld = word_vld_q;

endmodule

// File: tb/tb_byteena_reg_bank.sv
// tb/tb_byteena_reg_bank.sv - scoreboard bench for byteena_reg_bank
module tb_byteena_reg_bank;

  localparam int DW = 16, DP = 8, AW = 3, NB = 2;
  localparam int DWB = 32, DPB = 5, AWB = 3, NBB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic areset_n = 1'b0;

  logic          wr_valid = 0, wr_ready, rd_req = 0, rd_valid, clr = 0, busy;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0, rd_data;
  logic [NB-1:0] byteena = '0;
  logic [DP-1:0] word_vld;

  logic           wr_valid_b = 0, wr_ready_b, rd_req_b = 0, rd_valid_b, clr_b = 0, busy_b;
  logic [AWB-1:0] wr_addr_b = '0, rd_addr_b = '0;
  logic [DWB-1:0] wr_data_b = '0, rd_data_b;
  logic [NBB-1:0] byteena_b = '0;
  logic [DPB-1:0] word_vld_b;

  byteena_reg_bank #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .areset_n(areset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .byteena(byteena), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .clr(clr),
    .busy(busy), .word_vld(word_vld));

  byteena_reg_bank #(.DATA_W(DWB), .DEPTH(DPB)) dut_b (
    .clk(clk), .areset_n(areset_n), .wr_valid(wr_valid_b), .wr_ready(wr_ready_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .byteena(byteena_b), .rd_req(rd_req_b),
    .rd_addr(rd_addr_b), .rd_valid(rd_valid_b), .rd_data(rd_data_b), .clr(clr_b),
    .busy(busy_b), .word_vld(word_vld_b));

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays plus a countdown for the clear sweep.
  logic [DW-1:0] m_mem [DP];
  logic [DP-1:0] m_vld = '0;
  int            m_clr_left = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_rd = '0;
  logic [DW-1:0] mon_e;
  logic [DWB-1:0] exp_qb [$];
  logic [DWB-1:0] mon_eb;

  always @(negedge clk) begin
    if (areset_n) begin
      chk("rd_valid", rd_valid, exp_q.size() != 0);
      if (rd_valid && exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("rd_data", rd_data, mon_e);
        last_rd = mon_e;
      end else if (!rd_valid) begin
        chk("rd_hold", rd_data, last_rd);
      end
      chk("b_rd_valid", rd_valid_b, exp_qb.size() != 0);
      if (rd_valid_b && exp_qb.size() != 0) begin
        mon_eb = exp_qb.pop_front();
        chk("b_rd_data", rd_data_b, mon_eb);
      end
    end
  end

  task automatic step(input bit wv, input int wa, input logic [DW-1:0] wd, input logic [NB-1:0] be,
                      input bit rr, input int ra, input bit c);
    bit idle, acc;
    logic [DW-1:0] nw, rexp;
    wr_valid = wv; wr_addr = AW'(wa); wr_data = wd; byteena = be;
    rd_req = rr; rd_addr = AW'(ra); clr = c;
    idle = (m_clr_left == 0);
    acc  = wv && idle && !c;
    nw   = (wa < DP) ? m_mem[wa] : '0;
    for (int i = 0; i < NB; i++) if (be[i]) nw[i*8 +: 8] = wd[i*8 +: 8];
    if (acc && wa == ra && wa < DP && be != 0) rexp = nw;
    else if (ra < DP && m_vld[ra]) rexp = m_mem[ra];
    else rexp = '0;
    #1;
    chk("wr_ready", wr_ready, idle && !c);
    chk("busy", busy, !idle);
    chk("word_vld", word_vld, m_vld);
    @(posedge clk);
    if (rr) exp_q.push_back(rexp);
    if (acc && wa < DP && be != 0) begin
      m_mem[wa] = nw;
      m_vld[wa] = 1'b1;
    end
    if (idle && c) begin
      m_vld = '0;
      foreach (m_mem[i]) m_mem[i] = '0;
      m_clr_left = DP;
    end else if (m_clr_left > 0) begin
      m_clr_left--;
    end
    #1;
  endtask

  task automatic idle_step();
    step(0, 0, '0, '0, 0, 0, 0);
  endtask

  task automatic b_step(input bit wv, input int wa, input logic [DWB-1:0] wd, input logic [NBB-1:0] be,
                        input bit rr, input int ra, input bit c, input logic [DWB-1:0] rexp);
    wr_valid_b = wv; wr_addr_b = AWB'(wa); wr_data_b = wd; byteena_b = be;
    rd_req_b = rr; rd_addr_b = AWB'(ra); clr_b = c;
    @(posedge clk);
    if (rr) exp_qb.push_back(rexp);
    #1;
  endtask

  task automatic enter_reset();
    areset_n = 1'b0;
    wr_valid = 0; rd_req = 0; clr = 0; wr_valid_b = 0; rd_req_b = 0; clr_b = 0;
    exp_q.delete(); exp_qb.delete();
    last_rd = '0; m_vld = '0; m_clr_left = 0;
  endtask

  task automatic leave_reset();
    repeat (2) @(posedge clk);
    #1;
    areset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    enter_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_word_vld", word_vld, 0);
    leave_reset();

    // Full write then read back
    step(1, 3, 16'hABCD, 2'b11, 0, 0, 0);
    step(0, 0, '0, '0, 1, 3, 0);
    idle_step();
    chk("t1_word_vld", word_vld, 8'b0000_1000);

    // Partial-lane merges
    step(1, 3, 16'h1234, 2'b01, 0, 0, 0);
    step(1, 3, 16'h5600, 2'b10, 0, 0, 0);
    step(0, 0, '0, '0, 1, 3, 0);
    idle_step();

    // Same-edge write/read forwarding
    step(1, 5, 16'h0000, 2'b11, 0, 0, 0);
    step(1, 5, 16'hFFFF, 2'b10, 1, 5, 0);
    step(0, 0, '0, '0, 1, 5, 0);
    idle_step();

    // Clear sweep: colliding write refused, extra clr ignored, reads return 0
    step(1, 1, 16'h1111, 2'b11, 0, 0, 0);
    step(1, 6, 16'h6666, 2'b11, 0, 0, 0);
    step(1, 2, 16'h2222, 2'b11, 1, 3, 1);
    for (int i = 0; i < DP; i++) step(1, i, 16'hBEEF, 2'b11, 1, i, (i == 3));
    chk("t4_word_vld", word_vld, 0);
    step(1, 6, 16'hC0DE, 2'b11, 0, 0, 0);
    step(0, 0, '0, '0, 1, 6, 0);
    idle_step();

    // Asynchronous reset in cycle 4 of a clear
    step(1, 0, 16'h0F0F, 2'b11, 0, 0, 0);
    step(0, 0, '0, '0, 0, 0, 1);
    step(0, 0, '0, '0, 0, 0, 0);
    step(0, 0, '0, '0, 0, 0, 0);
    step(0, 0, '0, '0, 1, 0, 0);
    chk("pre_rst_rd_valid", rd_valid, 1);
    chk("pre_rst_busy", busy, 1);
    enter_reset();
    #1;
    chk("async_busy", busy, 0);
    chk("async_rd_valid", rd_valid, 0);
    chk("async_word_vld", word_vld, 0);
    chk("async_wr_ready", wr_ready, 0);
    leave_reset();
    for (int i = 0; i < DP; i++) step(0, 0, '0, '0, 1, i, 0);
    idle_step();

    // Known-zero storage, then randomized traffic
    step(0, 0, '0, '0, 0, 0, 1);
    repeat (DP) idle_step();
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 70, $urandom_range(0, DP - 1), DW'($urandom),
           NB'($urandom), $urandom_range(0, 99) < 60, $urandom_range(0, DP - 1),
           $urandom_range(0, 49) == 0);
    end
    repeat (DP + 2) idle_step();
    chk("drain", exp_q.size(), 0);

    // Non-power-of-two depth, 32-bit words
    b_step(0, 0, '0, '0, 0, 0, 1, '0);
    repeat (DPB + 1) b_step(0, 0, '0, '0, 0, 0, 0, '0);
    chk("b_busy_done", busy_b, 0);
    chk("b_wr_ready", wr_ready_b, 1);
    b_step(1, 6, 32'h12345678, 4'b1111, 0, 0, 0, '0);
    chk("b_oob_word_vld", word_vld_b, 0);
    b_step(0, 0, '0, '0, 1, 6, 0, 32'h0);
    b_step(1, 4, 32'hDEADBEEF, 4'b1010, 0, 0, 0, '0);
    b_step(0, 0, '0, '0, 1, 4, 0, 32'hDE00BE00);
    b_step(0, 0, '0, '0, 0, 0, 0, '0);
    chk("b_word_vld", word_vld_b, 5'b10000);
    b_step(0, 0, '0, '0, 0, 0, 0, '0);
    chk("b_drain", exp_qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byteena_reg_bank.md
Name: byteena_reg_bank

Overview:
- Clocked, parametrised successor to the team's 16-bit byte-enable latch: a DEPTH-word bank of DATA_W-bit registers with per-byte write enables.
- Write port uses a valid/ready handshake. Read port has fixed 1-cycle latency with read-after-write forwarding.
- A clear command zeros the whole bank through a sequential sweep.
- Sits between a bus-slave decoder and downstream logic as a control/status register store.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8 and ≥ 8.
- DEPTH, 8, number of words; ≥ 2; need not be a power of two.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- NUM_BYTES, DATA_W/8, byte lanes per word; derived.

Ports:
- clk  in  1  single clock, rising edge.
- areset_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  bank can accept a write this cycle.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  DATA_W  write data.
- byteena  in  NUM_BYTES  bit i enables wr_data[8i+7:8i].
- rd_req  in  1  read request.
- rd_addr  in  ADDR_W  read word address.
- rd_valid  out  1  rd_data valid; pulses 1 cycle after rd_req.
- rd_data  out  DATA_W  read result.
- clr  in  1  start a bank clear.
- busy  out  1  clear sweep in progress.
- word_vld  out  DEPTH  bit k set if word k has been written since reset/clear.

Behaviour:
- Interface (decided): one clock, clk. Reset areset_n is asynchronous and active-low. All state is reset on the falling edge of areset_n, independent of clk.
- Reset values: wr_ready=0 while areset_n low, 1 from the first cycle after deassertion. rd_valid=0, rd_data=0, busy=0, word_vld=0, FSM=IDLE. Storage array is not reset.
- Write acceptance: a write is accepted when wr_valid && wr_ready at a clk edge.
  - wr_ready = (state==IDLE) && !clr. It does not depend on wr_valid.
  - Byte lane i of word[wr_addr] takes wr_data lane i if byteena[i]; other lanes hold their value.
  - word_vld[wr_addr] is set if any byteena bit is 1.
  - An accepted write with byteena=0 is a no-op.
  - wr_addr ≥ DEPTH: the write is accepted and discarded.
- Read: rd_req at edge N gives rd_valid=1 and rd_data at edge N+1.
  - rd_data = word[rd_addr] masked to 0 when word_vld[rd_addr]=0.
  - rd_addr ≥ DEPTH returns 0.
  - rd_data holds its last value when rd_valid=0.
- Forwarding: if a write is accepted on the same edge as rd_req to the same address, rd_data returns the post-merge word: enabled lanes new, other lanes old.
- Back-to-back: a write and a read every cycle are sustained in IDLE, with no bubbles.
- FSM states:
  - IDLE: clr=1 → CLEAR. All word_vld bits clear on that edge, clear pointer=0, busy=1.
  - CLEAR: each cycle writes 0 to word[ptr] and increments ptr. At ptr==DEPTH-1 it writes the last word and returns to IDLE. The sweep lasts exactly DEPTH cycles, then busy=0.
  - clr during CLEAR is ignored; the sweep does not restart.
- During CLEAR: wr_ready=0. Reads remain legal and return 0, since word_vld=0.
- clr and wr_valid on the same cycle in IDLE: clr wins and the write is not accepted (wr_ready=0).
- Reset mid-sweep: immediate return to IDLE with all outputs at reset values. The storage contents are then unspecified but unobservable, because word_vld=0.

Decomposition:
- Package byteena_reg_bank_pkg holds:
  - state enum {IDLE, CLEAR};
  - function num_bytes(DATA_W);
  - localparam BYTE_W=8.
- One sub-module, byteena_merge: combinational. Inputs old_word, new_word, byteena; output merged_word. It is shared by the write path and the forwarding path.
- The top holds the storage, FSM, word_vld and read register.

Test Plan:
1. Reset, write addr 3, data 16'hABCD, byteena 2'b11; read addr 3 next cycle → rd_valid one cycle after rd_req, rd_data=16'hABCD, word_vld=8'b0000_1000.
2. Word 3=16'hABCD; write 16'h1234 with byteena 2'b01, then 16'h5600 with byteena 2'b10 → read returns 16'h5634.
3. Word 5=16'h0000 (written); same-cycle write 16'hFFFF with byteena 2'b10 and read addr 5 → rd_data=16'hFF00 at N+1.
4. Several words written; pulse clr with wr_valid=1 → write not accepted, busy high exactly 8 cycles, wr_ready=0 throughout, all reads return 0, word_vld=0, and a write after busy falls succeeds.
5. Assert areset_n low mid-sweep (cycle 4 of CLEAR) → busy=0, rd_valid=0, word_vld=0 immediately without a clk edge. A read of any address after release returns 0.
6. DEPTH=5, DATA_W=32: write addr 6 → no word_vld change; read addr 6 → 0. Write 32'hDEADBEEF, byteena 4'b1010, to addr 4 → read 32'hDE00BE00.
